// File: rtl/ad_serial_capture_mc.sv
// ---------------------------------------------------------------------------
// ad_serial_capture_mc
//
// Capture controller for CH_NUM AD7352-style serial ADCs that share one
// chip-select and one serial clock. Each conversion frame is FRAME_W bits
// (LEAD_Z leading bits, DATA_W result bits, TRAIL_Z trailing bits), shifted
// in MSB first on every ad_clk rising edge. Frames repeat every CONV_PERIOD
// clk_50M cycles, either for sample_num frames or continuously
// (sample_num = 0) until stop. Each frame's results are packed with channel 0
// in the LSBs and written to a first-word-fall-through output FIFO.
//
// Ports
//   clk_50M, rst_n          system clock, asynchronous active-low reset
//   start, stop             one-cycle control pulses from the sequencer
//   sample_num              frames per burst, 0 = continuous
//   ad_in                   one serial data line per ADC
//   ad_cs, ad_clk           shared chip select (active low), serial clock
//   busy, done, sample_idx  burst status and completed-frame count
//   out_data/valid/ready    FIFO read port
//   overflow                sticky: a frame arrived while the FIFO was full
//   dbg_state               current controller state
//
// Read handshake: out_valid is high whenever the FIFO holds a word, and
// out_data is then the oldest word. A word is consumed on every clk_50M edge
// where out_valid and out_ready are both high; out_ready alone does nothing.
// ---------------------------------------------------------------------------
module ad_serial_capture_mc #(
    parameter int CH_NUM      = 2,
    parameter int DATA_W      = 12,
    parameter int LEAD_Z      = 2,
    parameter int TRAIL_Z     = 2,
    parameter int HALF_DIV    = 1,
    parameter int CONV_PERIOD = 50,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                     clk_50M,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic [15:0]              sample_num,
    input  logic [CH_NUM-1:0]        ad_in,
    output logic                     ad_cs,
    output logic                     ad_clk,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              sample_idx,
    output logic [CH_NUM*DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overflow,
    output logic [2:0]               dbg_state
);

    localparam int FRAME_W = LEAD_Z + DATA_W + TRAIL_Z;
    localparam int WORD_W  = CH_NUM * DATA_W;
    // Leading bits fall off the top of the shifter, so only the result and
    // trailing bits need to be held.
    localparam int SHR_W   = DATA_W + TRAIL_Z;
    localparam int DIV_W   = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int BIT_W   = $clog2(FRAME_W + 1);
    localparam int PER_W   = (CONV_PERIOD > 1) ? $clog2(CONV_PERIOD) : 1;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(CONV_PERIOD - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, QUIET, FINISH} state_t;

    state_t                       state_q, state_d;
    logic                         cs_q, cs_d;
    logic                         sclk_q, sclk_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         push_q, push_d;
    logic                         stop_q, stop_d;
    logic                         ovf_q, ovf_d;
    logic [15:0]                  idx_q, idx_d;
    logic [15:0]                  num_q, num_d;
    logic [DIV_W-1:0]             div_q, div_d;
    logic [BIT_W-1:0]             bit_q, bit_d;
    logic [PER_W-1:0]             per_q, per_d;
    logic [CH_NUM-1:0][SHR_W-1:0] shr_q, shr_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [WORD_W-1:0]            mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0]            word;
    logic                         pop, full, wr_en;

    // Packed frame result, channel 0 in the LSBs.
    always_comb begin
        word = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            word[c*DATA_W +: DATA_W] = shr_q[c][TRAIL_Z +: DATA_W];
        end
    end

    // A full FIFO still accepts a word when a pop frees a slot in the same cycle.
    assign pop   = (cnt_q != '0) && out_ready;
    assign full  = (cnt_q == DEPTH_C);
    assign wr_en = push_q && (!full || pop);

    always_comb begin
        state_d  = state_q;
        cs_d     = cs_q;
        sclk_d   = sclk_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        push_d   = 1'b0;
        stop_d   = stop_q;
        ovf_d    = ovf_q;
        idx_d    = idx_q;
        num_d    = num_q;
        div_d    = div_q + 1'b1;
        bit_d    = bit_q;
        shr_d    = shr_q;
        // Conversion period counter restarts at each ad_cs fall and parks at its last value.
        per_d    = (per_q == PER_LAST) ? per_q : per_q + 1'b1;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (busy_q && stop) begin
            stop_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    num_d   = sample_num;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                    stop_d  = 1'b0;
                    busy_d  = 1'b1;
                    cs_d    = 1'b0;
                    per_d   = '0;
                    div_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    sclk_d  = 1'b0;
                    bit_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        // Edge that raises ad_clk also samples every data line.
                        sclk_d = 1'b1;
                        bit_d  = bit_q + 1'b1;
                        for (int c = 0; c < CH_NUM; c++) begin
                            shr_d[c] = {shr_q[c][SHR_W-2:0], ad_in[c]};
                        end
                    end else if (bit_q == BIT_LAST) begin
                        cs_d    = 1'b1;
                        push_d  = 1'b1;
                        state_d = QUIET;
                    end else begin
                        sclk_d = 1'b0;
                    end
                end
            end
            QUIET: begin
                if (per_q == PER_LAST) begin
                    if (stop_q || (num_q != 16'd0 && idx_q == num_q)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = FINISH;
                    end else begin
                        cs_d    = 1'b0;
                        per_d   = '0;
                        div_d   = '0;
                        state_d = SETUP;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The frame is pushed one cycle after ad_cs rises; the count always
        // advances, even when the word has to be dropped.
        if (push_q) begin
            idx_d = idx_q + 16'd1;
            if (!wr_en) begin
                ovf_d = 1'b1;
            end
        end
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cs_q     <= 1'b1;
            sclk_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            push_q   <= 1'b0;
            stop_q   <= 1'b0;
            ovf_q    <= 1'b0;
            idx_q    <= '0;
            num_q    <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            per_q    <= '0;
            shr_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            cs_q     <= cs_d;
            sclk_q   <= sclk_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            push_q   <= push_d;
            stop_q   <= stop_d;
            ovf_q    <= ovf_d;
            idx_q    <= idx_d;
            num_q    <= num_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            per_q    <= per_d;
            shr_q    <= shr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk_50M) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= word;
        end
    end

    assign ad_cs      = cs_q;
    assign ad_clk     = sclk_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sample_idx = idx_q;
    assign overflow   = ovf_q;
    assign out_valid  = (cnt_q != '0);
    assign out_data   = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ad_serial_capture_mc.sv
// ---------------------------------------------------------------------------
// tb_ad_serial_capture_mc
//
// Bench for ad_serial_capture_mc. An ADC model answers every ad_cs frame with
// chosen or random results (random leading/trailing bits), and a queue-based
// reference predicts the output FIFO, sample count and overflow flag from the
// frame results and the consumer's out_ready. Timing of ad_cs / ad_clk is
// measured in clk_50M cycles on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ad_serial_capture_mc;

    localparam int CH_NUM      = 2;
    localparam int DATA_W      = 12;
    localparam int LEAD_Z      = 2;
    localparam int TRAIL_Z     = 2;
    localparam int HALF_DIV    = 1;
    localparam int CONV_PERIOD = 50;
    localparam int FIFO_DEPTH  = 16;
    localparam int FRAME_W     = LEAD_Z + DATA_W + TRAIL_Z;
    localparam int WORD_W      = CH_NUM * DATA_W;

    // ---------------- clock / reset / DUT ----------------
    logic              clk_50M;
    logic              rst_n;
    logic              start;
    logic              stop;
    logic [15:0]       sample_num;
    logic [CH_NUM-1:0] ad_in;
    logic              ad_cs;
    logic              ad_clk;
    logic              busy;
    logic              done;
    logic [15:0]       sample_idx;
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              overflow;
    logic [2:0]        dbg_state;

    initial clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    ad_serial_capture_mc #(
        .CH_NUM(CH_NUM), .DATA_W(DATA_W), .LEAD_Z(LEAD_Z), .TRAIL_Z(TRAIL_Z),
        .HALF_DIV(HALF_DIV), .CONV_PERIOD(CONV_PERIOD), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_50M(clk_50M), .rst_n(rst_n), .start(start), .stop(stop),
        .sample_num(sample_num), .ad_in(ad_in), .ad_cs(ad_cs), .ad_clk(ad_clk),
        .busy(busy), .done(done), .sample_idx(sample_idx), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow),
        .dbg_state(dbg_state)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [WORD_W-1:0] exp_q[$];
    int                exp_idx;
    logic              exp_ovf;
    int                falls_burst;
    int                done_cnt;
    int                start_seq;
    int                seen_seq;
    bit                tbl_mode;
    logic [11:0]       tbl0 [4] = '{12'hABC, 12'h123, 12'h7FF, 12'h000};
    logic [11:0]       tbl1 [4] = '{12'h555, 12'hAAA, 12'hFFF, 12'h001};

    int                cyc;
    logic              prev_cs;
    logic              prev_clk;
    int                ptr;
    logic [FRAME_W-1:0] fr [CH_NUM];
    logic [WORD_W-1:0] cur_word;
    int                rises;
    int                last_rise_cyc;
    int                last_fall_cyc;
    int                hi_cnt;
    bit                saw_low;
    bit                chk_push;
    bit                pop_m;
    int                n_before;
    logic [11:0]       dv;
    logic [1:0]        lz;
    logic [1:0]        tz;

    // ADC model, timing monitor and FIFO reference, all on the falling edge.
    always @(negedge clk_50M) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_idx  = 0;
            exp_ovf  = 1'b0;
            prev_cs  = 1'b1;
            prev_clk = 1'b1;
            ptr      = 0;
            rises    = 0;
            saw_low  = 1'b1;
            chk_push = 1'b0;
            ad_in    = '0;
        end else begin
            cyc++;
            if (seen_seq != start_seq) begin
                seen_seq    = start_seq;
                exp_idx     = 0;
                exp_ovf     = 1'b0;
                falls_burst = 0;
            end
            if (chk_push) begin
                chk("idx_after_push", 32'(sample_idx), 32'(exp_idx));
                chk("ovf_after_push", 32'(overflow), 32'(exp_ovf));
                chk_push = 1'b0;
            end

            // FIFO read side
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("out_data", 32'(out_data), 32'(exp_q[0]));
            end
            n_before = exp_q.size();
            pop_m    = out_ready && (n_before != 0);
            if (pop_m) begin
                void'(exp_q.pop_front());
            end

            // frame start: choose this frame's results
            if (prev_cs && !ad_cs) begin
                chk("clk_high_at_fall", 32'(ad_clk), 1);
                if (falls_burst > 0) begin
                    chk("cs_period", 32'(cyc - last_fall_cyc), CONV_PERIOD);
                end
                last_fall_cyc = cyc;
                rises   = 0;
                hi_cnt  = 0;
                saw_low = 1'b0;
                ptr     = 0;
                for (int c = 0; c < CH_NUM; c++) begin
                    if (tbl_mode && falls_burst < 4) begin
                        dv = (c == 0) ? tbl0[falls_burst] : tbl1[falls_burst];
                    end else begin
                        dv = 12'($urandom_range(0, 4095));
                    end
                    lz = 2'($urandom_range(0, 3));
                    tz = 2'($urandom_range(0, 3));
                    fr[c] = {lz, dv, tz};
                    cur_word[c*DATA_W +: DATA_W] = dv;
                end
                falls_burst++;
            end

            if (!ad_cs) begin
                if (!saw_low) begin
                    if (ad_clk) begin
                        hi_cnt++;
                    end else begin
                        chk("setup_high_cycles", 32'(hi_cnt), HALF_DIV);
                        saw_low = 1'b1;
                    end
                end
                // new bit presented while ad_clk is low, MSB first
                if (prev_clk && !ad_clk && ptr < FRAME_W) begin
                    for (int c = 0; c < CH_NUM; c++) begin
                        ad_in[c] = fr[c][FRAME_W-1-ptr];
                    end
                    ptr++;
                end
                if (!prev_clk && ad_clk) begin
                    rises++;
                    last_rise_cyc = cyc;
                end
            end else begin
                chk("clk_idle_high", 32'(ad_clk), 1);
                if (!prev_cs) begin
                    chk("rises_per_frame", 32'(rises), FRAME_W);
                    chk("cs_rise_delay", 32'(cyc - last_rise_cyc), HALF_DIV);
                    // push lands on the next rising edge, together with any pop
                    if (n_before < FIFO_DEPTH || pop_m) begin
                        exp_q.push_back(cur_word);
                    end else begin
                        exp_ovf = 1'b1;
                    end
                    exp_idx  = (exp_idx + 1) % 65536;
                    chk_push = 1'b1;
                end
            end

            if (done) begin
                done_cnt++;
                chk("done_busy_low", 32'(busy), 0);
                chk("done_idx", 32'(sample_idx), 32'(exp_idx));
            end
            prev_cs  = ad_cs;
            prev_clk = ad_clk;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    task automatic go(input logic [15:0] n);
        sample_num = n;
        start      = 1'b1;
        start_seq++;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd_ready);
        int base;
        int k;
        base = done_cnt;
        k    = 0;
        while (done_cnt == base && k < budget) begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        chk("done_seen", 32'(done_cnt != base), 1);
    endtask

    task automatic wait_falls(input int n, input int budget);
        int k;
        k = 0;
        while (falls_burst < n && k < budget) begin
            tick();
            k++;
        end
        chk("falls_reached", 32'(falls_burst >= n), 1);
    endtask

    task automatic wait_cs(input logic lvl, input int budget);
        int k;
        k = 0;
        while (ad_cs !== lvl && k < budget) begin
            tick();
            k++;
        end
        chk("cs_level_reached", 32'(ad_cs), 32'(lvl));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d0;
        int n;
        rst_n      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        sample_num = '0;
        out_ready  = 1'b0;
        tbl_mode   = 1'b0;
        done_cnt   = 0;
        start_seq  = 0;
        seen_seq   = 0;
        falls_burst = 0;
        cyc        = 0;
        repeat (3) @(posedge clk_50M);
        #1;
        chk("rst_ad_cs", 32'(ad_cs), 1);
        chk("rst_ad_clk", 32'(ad_clk), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sample_idx", 32'(sample_idx), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_overflow", 32'(overflow), 0);
        rst_n = 1'b1;
        settle(3);

        // burst of four known frames, consumer always ready
        tbl_mode  = 1'b1;
        out_ready = 1'b1;
        d0 = done_cnt;
        go(16'd4);
        wait_done(400, 1'b0);
        settle(60);
        chk("burst_idx", 32'(sample_idx), 4);
        chk("burst_frames", 32'(falls_burst), 4);
        chk("burst_done_once", 32'(done_cnt - d0), 1);
        chk("burst_busy", 32'(busy), 0);
        tbl_mode = 1'b0;

        // backpressure: 20 frames into a 16-word FIFO, then drain
        out_ready = 1'b0;
        go(16'd20);
        wait_done(1500, 1'b0);
        settle(5);
        chk("bp_idx", 32'(sample_idx), 20);
        chk("bp_overflow", 32'(overflow), 1);
        chk("bp_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        settle(20);
        chk("bp_drained", 32'(out_valid), 0);

        // exactly full, then push and pop in the same cycle on a full FIFO
        out_ready = 1'b0;
        go(16'd16);
        wait_done(1200, 1'b0);
        settle(5);
        chk("full_no_ovf", 32'(overflow), 0);
        go(16'd1);
        wait_cs(1'b0, 100);
        wait_cs(1'b1, 100);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_done(200, 1'b0);
        settle(5);
        chk("pushpop_full_ovf", 32'(overflow), 0);
        chk("pushpop_idx", 32'(sample_idx), 1);
        out_ready = 1'b1;
        settle(25);

        // random burst lengths with a random consumer
        for (int i = 0; i < 3; i++) begin
            n = $urandom_range(1, 6);
            go(16'(n));
            wait_done(600, 1'b1);
            settle(5);
            chk("rnd_idx", 32'(sample_idx), 32'(n));
            out_ready = 1'b1;
            settle(20);
        end

        // stop while idle has no lasting effect
        pulse_stop();
        settle(3);
        go(16'd2);
        wait_done(300, 1'b0);
        settle(60);
        chk("idle_stop_idx", 32'(sample_idx), 2);
        chk("idle_stop_frames", 32'(falls_burst), 2);

        // continuous mode, stop in the middle of the eighth frame
        go(16'd0);
        wait_falls(8, 600);
        settle(10);
        pulse_stop();
        wait_done(200, 1'b0);
        settle(80);
        chk("cont_stop_idx", 32'(sample_idx), 8);
        chk("cont_stop_frames", 32'(falls_burst), 8);
        chk("cont_stop_busy", 32'(busy), 0);

        // a second start and a sample_num change mid-burst are ignored
        d0 = done_cnt;
        go(16'd4);
        wait_falls(2, 200);
        sample_num = 16'd1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        wait_done(400, 1'b0);
        settle(60);
        chk("restart_idx", 32'(sample_idx), 4);
        chk("restart_frames", 32'(falls_burst), 4);
        chk("restart_done_once", 32'(done_cnt - d0), 1);

        // reset in the middle of a frame with a word waiting in the FIFO
        out_ready = 1'b0;
        go(16'd3);
        wait_falls(2, 200);
        settle(8);
        chk("pre_rst_valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_ad_cs", 32'(ad_cs), 1);
        chk("midrst_ad_clk", 32'(ad_clk), 1);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_idx", 32'(sample_idx), 0);
        settle(3);
        rst_n = 1'b1;
        settle(3);

        // recovery after reset
        out_ready = 1'b1;
        go(16'd1);
        wait_done(200, 1'b0);
        settle(10);
        chk("recover_idx", 32'(sample_idx), 1);
        chk("recover_valid", 32'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
